// File: rtl/spi_text_tx_pkg.sv
// Shared types and constants for the SPI text transmitter: FSM states,
// default timing parameters and the character width.
package spi_text_tx_pkg;

  localparam int CHAR_W      = 8;
  localparam int CNT_W       = 8;
  localparam int CLK_DIV_DEF = 4;
  localparam int CS_GAP_DEF  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

endpackage

// File: rtl/spi_text_tx_clk_div.sv
// Phase timer: counts 0..i_tc while enabled and flags the terminal count,
// wrapping so that consecutive phases need no extra clear cycle.
module spi_clk_div
  import spi_text_tx_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [CNT_W-1:0] i_tc,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;

  assign o_tick = i_en && !i_clr && (r_cnt == i_tc);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_text_tx.sv
// SPI mode-0 byte transmitter: one chip-select frame per accepted byte,
// MSB first, with setup/hold around the SCK burst and a minimum CS gap.
module spi_text_tx
  import spi_text_tx_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int CS_GAP  = CS_GAP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CHAR_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_cs_n,
  output logic              tx_done,
  output logic              busy
);

  localparam logic [CNT_W-1:0] TC_HALF = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] TC_GAP  = CNT_W'(CS_GAP - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CHAR_W-1:0] r_shift;
  logic [2:0]        r_bit;
  logic              r_sck, r_mosi, r_cs_n, r_done, r_busy, r_ready;
  logic              w_sck_nxt, w_mosi_nxt, w_cs_n_nxt, w_done_nxt;
  logic              w_tick, w_hs, w_fall, w_div_en, w_div_clr;
  logic [CNT_W-1:0]  w_tc;

  assign w_hs      = tx_valid && r_ready;
  assign w_div_en  = (r_state != ST_IDLE);
  assign w_div_clr = (r_state == ST_IDLE);
  assign w_tc      = (r_state == ST_GAP) ? TC_GAP : TC_HALF;
  assign w_fall    = (r_state == ST_SHIFT) && w_tick && r_sck;

  spi_clk_div u_div (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (w_div_en),
    .i_clr  (w_div_clr),
    .i_tc   (w_tc),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // SHIFT always ends on a low phase; bit counter wrapped to 0 marks the 8th fall.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_hs)   w_state_nxt = ST_SETUP;
      ST_SETUP: if (w_tick) w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_tick && !r_sck && (r_bit == 3'd0)) w_state_nxt = ST_HOLD;
      ST_HOLD:  if (w_tick) w_state_nxt = ST_GAP;
      ST_GAP:   if (w_tick) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_sck_nxt  = 1'b0;
    w_mosi_nxt = 1'b0;
    w_cs_n_nxt = 1'b1;
    w_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_SETUP: begin
        w_cs_n_nxt = 1'b0;
        w_mosi_nxt = (r_state == ST_IDLE) ? tx_data[CHAR_W-1] : r_mosi;
      end
      ST_SHIFT: begin
        w_cs_n_nxt = 1'b0;
        w_sck_nxt  = (r_state == ST_SHIFT) ? (r_sck ^ w_tick) : 1'b1;
        w_mosi_nxt = w_fall ? r_shift[CHAR_W-2] : r_mosi;
      end
      ST_HOLD: begin
        w_cs_n_nxt = 1'b0;
        w_mosi_nxt = r_mosi;
      end
      ST_GAP:  w_done_nxt = (r_state == ST_HOLD);
      default: w_done_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      r_ready <= (w_state_nxt == ST_IDLE);
    end
  end

  // The byte register carries data only, so it is never reset.
  always_ff @(posedge clk) begin
    if (w_hs) begin
      r_shift <= tx_data;
    end else if (w_fall) begin
      r_shift <= {r_shift[CHAR_W-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (r_state == ST_IDLE)) begin
      r_bit <= '0;
    end else if (w_fall) begin
      r_bit <= r_bit + 1'b1;
    end
  end

  assign tx_ready = r_ready;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;
  assign spi_cs_n = r_cs_n;
  assign tx_done  = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_spi_text_tx.sv
// Bench for spi_text_tx: a default instance and a CLK_DIV=1 instance, with a
// scoreboard monitor that decodes each SPI frame into a small text RAM.
module tb_spi_text_tx;
  import spi_text_tx_pkg::*;

  localparam int DA = 4;
  localparam int GA = 2;
  localparam int DB = 1;
  localparam int GB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, tx_valid;
  logic [1:0] tx_ready, sck, mosi, cs_n, done, busy;
  logic [7:0] tx_data [2];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] exp_q [$];
  logic [7:0] ram [16];
  int         ram_wa = 0;

  spi_text_tx #(.CLK_DIV(DA), .CS_GAP(GA)) dut_a (
    .clk(clk), .rst(rst[0]), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .spi_sck(sck[0]), .spi_mosi(mosi[0]),
    .spi_cs_n(cs_n[0]), .tx_done(done[0]), .busy(busy[0])
  );

  spi_text_tx #(.CLK_DIV(DB), .CS_GAP(GB)) dut_b (
    .clk(clk), .rst(rst[1]), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .spi_sck(sck[1]), .spi_mosi(mosi[1]),
    .spi_cs_n(cs_n[1]), .tx_done(done[1]), .busy(busy[1])
  );

  task automatic check(input string name, input int act, input int req);
    n_total++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  // Monitor: decode MOSI at SCK rising edges, pop expected byte on tx_done.
  logic       prev_sck [2];
  logic       prev_cs  [2];
  logic [7:0] cap      [2];
  int         bits     [2];
  int         lowcnt   [2];
  int         hicnt    [2];
  int         last_rise[2];
  bit         had_frame[2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      prev_sck[i] = 1'b0; prev_cs[i] = 1'b1; cap[i] = '0; bits[i] = 0;
      lowcnt[i] = 0; hicnt[i] = 0; last_rise[i] = 0; had_frame[i] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        int d, g;
        logic [7:0] e;
        d = (i == 0) ? DA : DB;
        g = (i == 0) ? GA : GB;
        if (rst[i] !== 1'b0) begin
          prev_sck[i] = 1'b0; prev_cs[i] = 1'b1; hicnt[i] = 0;
          continue;
        end
        if (cs_n[i] == 1'b0) begin
          if (prev_cs[i]) begin
            if (had_frame[i]) begin
              n_total++;
              if (hicnt[i] >= g) n_pass++;
              else $display("FAIL cs_n gap[%0d]: high %0d cycles, need >= %0d", i, hicnt[i], g);
            end
            bits[i] = 0; lowcnt[i] = 0; cap[i] = '0;
          end
          lowcnt[i]++;
          if (sck[i] && !prev_sck[i]) begin
            if (bits[i] > 0) check($sformatf("sck period[%0d]", i), cyc - last_rise[i], 2 * d);
            last_rise[i] = cyc;
            cap[i] = {cap[i][6:0], mosi[i]};
            bits[i]++;
          end
        end else begin
          hicnt[i] = prev_cs[i] ? hicnt[i] + 1 : 1;
        end
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected tx_done[%0d]: byte 0x%02h, none expected", i, cap[i]);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte[%0d]", i), cap[i], e);
            check($sformatf("rise count[%0d]", i), bits[i], 8);
            check($sformatf("cs_n low cycles[%0d]", i), lowcnt[i], 18 * d);
            if (ram_wa < 16) begin
              ram[ram_wa] = cap[i];
              ram_wa++;
            end
          end
          had_frame[i] = 1'b1;
        end
        prev_sck[i] = sck[i];
        prev_cs[i]  = cs_n[i];
      end
    end
  end

  task automatic wait_ready(input int i, output int hs);
    int t = 0;
    while (!tx_ready[i] && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (!tx_ready[i]) begin
      n_total++;
      $display("FAIL ready timeout[%0d]: tx_ready=%0b after %0d cycles, required 1", i, tx_ready[i], t);
    end
    hs = cyc;
  endtask

  task automatic send(input int i, input logic [7:0] b, input bit expect_frame);
    int hs;
    @(negedge clk);
    tx_data[i]  = b;
    tx_valid[i] = 1'b1;
    wait_ready(i, hs);
    if (expect_frame) exp_q.push_back(b);
    @(negedge clk);
    tx_valid[i] = 1'b0;
    check("setup cs_n", cs_n[i], 0);
    check("setup sck", sck[i], 0);
    check("setup mosi", mosi[i], b[7]);
    check("setup ready", tx_ready[i], 0);
  endtask

  task automatic send_pair(input int i, input logic [7:0] b0, input logic [7:0] b1,
                           output int period);
    int h0, h1;
    @(negedge clk);
    tx_data[i]  = b0;
    tx_valid[i] = 1'b1;
    wait_ready(i, h0);
    exp_q.push_back(b0);
    @(negedge clk);
    tx_data[i] = b1;
    wait_ready(i, h1);
    exp_q.push_back(b1);
    @(negedge clk);
    tx_valid[i] = 1'b0;
    period = h1 - h0;
  endtask

  task automatic wait_idle(input int i);
    int t = 0;
    while (!(tx_ready[i] && exp_q.size() == 0) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("frames drained[%0d]", i), exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int period, ps, n, k;
    rst = 2'b11; tx_valid = 2'b00; tx_data[0] = '0; tx_data[1] = '0;
    repeat (3) @(negedge clk);
    check("reset ready", tx_ready[0], 0);
    check("reset cs_n", cs_n[0], 1);
    check("reset sck", sck[0], 0);
    check("reset mosi", mosi[0], 0);
    check("reset busy", busy[0], 0);
    check("reset done", done[0], 0);
    rst = 2'b00;
    @(negedge clk);
    check("ready after reset a", tx_ready[0], 1);
    check("ready after reset b", tx_ready[1], 1);

    // 0xA5 with defaults
    send(0, 8'hA5, 1'b1);
    check("busy in frame", busy[0], 1);
    wait_idle(0);

    // back-to-back with tx_valid held high
    send_pair(0, 8'h41, 8'h42, period);
    check("byte period div4", period, 75);
    wait_idle(0);

    // tx_valid toggling while the frame is in flight
    send(0, 8'h3C, 1'b1);
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!busy[0]) break;
      tx_valid[0] = ~tx_valid[0];
      tx_data[0]  = tx_data[0] + 8'h11;
    end
    tx_valid[0] = 1'b0;
    wait_idle(0);

    // reset during the 4th SCK high phase
    send(0, 8'h5A, 1'b0);
    ps = sck[0]; n = 0;
    for (int t = 0; t < 200 && n < 4; t++) begin
      @(negedge clk);
      if (sck[0] && !ps) n++;
      ps = sck[0];
    end
    check("abort rise reached", n, 4);
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort cs_n", cs_n[0], 1);
    check("abort sck", sck[0], 0);
    check("abort done", done[0], 0);
    check("abort busy", busy[0], 0);
    check("abort ready in rst", tx_ready[0], 0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort ready after rst", tx_ready[0], 1);
    repeat (5) @(negedge clk);
    check("abort no pending", exp_q.size(), 0);

    // CLK_DIV=1 instance
    send_pair(1, 8'hFF, 8'h00, period);
    check("byte period div1", period, 21);
    wait_idle(1);

    // text "HI" into the receiver RAM
    k = ram_wa;
    send(0, 8'h48, 1'b1);
    wait_idle(0);
    send(0, 8'h49, 1'b1);
    wait_idle(0);
    check("ram H", (k < 16) ? int'(ram[k]) : -1, 8'h48);
    check("ram I", (k + 1 < 16) ? int'(ram[k+1]) : -1, 8'h49);
    check("ram write count", ram_wa, k + 2);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spi_text_tx.md
SPI_TEXT_TX -- requirements
Module: spi_text_tx

Interface
REQ-001 Parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal range 1..255.
REQ-002 Parameter CS_GAP, default 2: minimum clk cycles spi_cs_n stays high between frames; legal range 1..255.
REQ-003 clk  input  1  core clock, 50 MHz; single clock domain.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 tx_data  input  8  ASCII byte to transmit.
REQ-006 tx_valid  input  1  tx_data is valid.
REQ-007 tx_ready  output  1  block accepts a byte this cycle.
REQ-008 spi_sck  output  1  SPI clock, mode 0 (CPOL=0, CPHA=0).
REQ-009 spi_mosi  output  1  serial data, MSB first.
REQ-010 spi_cs_n  output  1  active-low chip select, one frame per byte.
REQ-011 tx_done  output  1  one-cycle pulse at end of each frame.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 States: IDLE, SETUP, SHIFT, HOLD, GAP; all outputs are registered.
REQ-014 tx_ready SHALL equal (state == IDLE); the handshake completes on a cycle with tx_valid && tx_ready.
REQ-015 On handshake: latch tx_data into an 8-bit shift register; next cycle state=SETUP, spi_cs_n=0, spi_mosi=tx_data[7], spi_sck=0.
REQ-016 SETUP lasts CLK_DIV cycles, then enters SHIFT with the first SCK rising edge.
REQ-017 SHIFT produces 8 SCK high phases and 8 low phases, each CLK_DIV cycles (16*CLK_DIV cycles total).
REQ-018 spi_mosi changes only on SCK falling edges (next bit, MSB to LSB) and is stable across every rising edge.
REQ-019 After the 8th falling edge: enter HOLD (spi_sck=0, spi_cs_n=0) for CLK_DIV cycles.
REQ-020 HOLD exit: spi_cs_n=1, tx_done pulses for exactly 1 cycle, state=GAP for CS_GAP cycles, then IDLE.
REQ-021 Byte period, handshake to next possible handshake, SHALL be 18*CLK_DIV + CS_GAP + 1 cycles; with the defaults, 75 cycles.
REQ-022 tx_valid and tx_data are ignored outside IDLE; a byte is never dropped, duplicated or truncated.
REQ-023 Half-period counter: 8 bits, counts 0..CLK_DIV-1 and wraps; bit counter: 3 bits, counts 0..7; no counter overflows at CLK_DIV=255.
REQ-024 With CLK_DIV=1, SCK toggles every clk cycle and all timing rules still hold.
REQ-025 In IDLE and GAP: spi_sck=0, spi_cs_n=1, spi_mosi=0.

Reset
REQ-026 rst SHALL take priority over all other inputs.
REQ-027 While rst is high, the next edge sets: state=IDLE, spi_cs_n=1, spi_sck=0, spi_mosi=0, tx_done=0, busy=0, tx_ready=0 (the register is cleared).
REQ-028 tx_ready rises on the first cycle after rst deasserts.
REQ-029 rst mid-frame SHALL abort the frame: cs_n deasserts on the next edge, with no tx_done pulse and no partial SCK pulse shorter than 1 clk.

Structure
REQ-030 A shared package SHALL hold the state enum, the CLK_DIV/CS_GAP defaults and the 8-bit character width constant.
REQ-031 One sub-module, spi_clk_div, SHALL generate the half-period tick (enable, clear, terminal-count pulse).
REQ-032 The top level holds only the FSM, the shift register and the bit counter.

Verification
REQ-033 Defaults, send 0xA5: MOSI samples on rising edges = 1,0,1,0,0,1,0,1; cs_n low for 72 cycles; tx_done pulses once.
REQ-034 tx_valid held high with 0x41 then 0x42: successive handshakes are 75 cycles apart; cs_n is high for at least 2 cycles between frames.
REQ-035 tx_valid toggled every cycle during SHIFT: the captured byte is unchanged and there are exactly 8 rising edges.
REQ-036 rst asserted at the 4th rising edge: cs_n=1 next cycle, no tx_done pulse, tx_ready=1 one cycle after rst deasserts.
REQ-037 CLK_DIV=1, send 0xFF then 0x00: SCK period is 2 cycles, byte period is 21 cycles, and data decodes correctly.
REQ-038 Loopback into the SPI receiver and text RAM writer, sending "HI": RAM holds 0x48, 0x49 at consecutive addresses.
